// File: rtl/bch_dec2_seq.sv
// Sequential double-error-correcting binary BCH decoder over GF(2^M):
// serial Horner syndromes, inversion-free t=2 locator, serial Chien search.
module bch_dec2_seq #(
    parameter int unsigned M         = 4,
    parameter logic [M:0]  PRIM_POLY = 5'b10011
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2**M-2:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2**M-2:0]     out_data,
    output logic [1:0]          out_err_cnt,
    output logic                out_uncorrectable,
    output logic                busy
);

    localparam int unsigned N  = 2**M - 1;
    localparam int unsigned IW = M;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYND  = 3'd1;
    localparam logic [2:0] SOLVE = 3'd2;
    localparam logic [2:0] CHIEN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Multiply by alpha, reducing by the primitive polynomial.
    function automatic logic [M-1:0] mul_a(input logic [M-1:0] x);
        return {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : '0);
    endfunction

    // Multiply by alpha^-1: add p(x) when x is odd, then divide by x.
    function automatic logic [M-1:0] div_a(input logic [M-1:0] x);
        return {1'b0, x[M-1:1]} ^ (x[0] ? PRIM_POLY[M:1] : '0);
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < int'(M); i++) begin
            if (b[i]) p = p ^ aa;
            aa = mul_a(aa);
        end
        return p;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [N-1:0]  r_buf_q, r_buf_d;
    logic [M-1:0]  s1_q, s1_d;
    logic [M-1:0]  s3_q, s3_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [M-1:0]  c0_q, c0_d;
    logic [M-1:0]  c1_q, c1_d;
    logic [M-1:0]  c2_q, c2_d;
    logic [IW-1:0] j_q, j_d;
    logic [1:0]    root_cnt_q, root_cnt_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [1:0]    exp_cnt_q, exp_cnt_d;
    logic          unc_q, unc_d;

    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic [1:0]    out_err_cnt_q, out_err_cnt_d;
    logic          out_unc_q, out_unc_d;
    logic          busy_q, busy_d;

    logic [M-1:0]  s1_sq, s1_cu, d_val;

    always_comb begin
        state_d       = state_q;
        r_buf_d       = r_buf_q;
        s1_d          = s1_q;
        s3_d          = s3_q;
        idx_d         = idx_q;
        c0_d          = c0_q;
        c1_d          = c1_q;
        c2_d          = c2_q;
        j_d           = j_q;
        root_cnt_d    = root_cnt_q;
        mask_d        = mask_q;
        exp_cnt_d     = exp_cnt_q;
        unc_d         = unc_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_err_cnt_d = out_err_cnt_q;
        out_unc_d     = out_unc_q;
        s1_sq         = gf_mul(s1_q, s1_q);
        s1_cu         = gf_mul(s1_sq, s1_q);
        d_val         = s3_q ^ s1_cu;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    r_buf_d = in_data;
                    s1_d    = '0;
                    s3_d    = '0;
                    idx_d   = IW'(N - 1);
                    state_d = SYND;
                end
            end
            SYND: begin
                s1_d = mul_a(s1_q) ^ M'(r_buf_q[idx_q]);
                s3_d = mul_a(mul_a(mul_a(s3_q))) ^ M'(r_buf_q[idx_q]);
                if (idx_q == '0) state_d = SOLVE;
                else             idx_d   = idx_q - 1'b1;
            end
            SOLVE: begin
                // Scaled locator S1 + S1^2 x + D x^2 avoids a field inversion.
                unc_d     = 1'b0;
                exp_cnt_d = 2'd0;
                if (s1_q == '0) begin
                    if (s3_q != '0) unc_d = 1'b1;
                end else if (d_val == '0) begin
                    exp_cnt_d = 2'd1;
                end else begin
                    exp_cnt_d = 2'd2;
                end
                c0_d       = s1_q;
                c1_d       = s1_sq;
                c2_d       = d_val;
                j_d        = '0;
                root_cnt_d = 2'd0;
                mask_d     = '0;
                state_d    = CHIEN;
            end
            CHIEN: begin
                if (j_q == IW'(N)) begin
                    if (unc_q || (root_cnt_q != exp_cnt_q)) begin
                        out_data_d    = r_buf_q;
                        out_err_cnt_d = 2'd0;
                        out_unc_d     = 1'b1;
                    end else begin
                        out_data_d    = r_buf_q ^ mask_q;
                        out_err_cnt_d = root_cnt_q;
                        out_unc_d     = 1'b0;
                    end
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    // A root at alpha^-j marks an error at bit position j.
                    if (((c0_q ^ c1_q ^ c2_q) == '0) && (exp_cnt_q != 2'd0) && !unc_q) begin
                        mask_d[j_q] = 1'b1;
                        root_cnt_d  = (root_cnt_q == 2'd3) ? 2'd3 : root_cnt_q + 2'd1;
                    end
                    c1_d = div_a(c1_q);
                    c2_d = div_a(div_a(c2_q));
                    j_d  = j_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            r_buf_q       <= '0;
            s1_q          <= '0;
            s3_q          <= '0;
            idx_q         <= '0;
            c0_q          <= '0;
            c1_q          <= '0;
            c2_q          <= '0;
            j_q           <= '0;
            root_cnt_q    <= '0;
            mask_q        <= '0;
            exp_cnt_q     <= '0;
            unc_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_err_cnt_q <= '0;
            out_unc_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_buf_q       <= r_buf_d;
            s1_q          <= s1_d;
            s3_q          <= s3_d;
            idx_q         <= idx_d;
            c0_q          <= c0_d;
            c1_q          <= c1_d;
            c2_q          <= c2_d;
            j_q           <= j_d;
            root_cnt_q    <= root_cnt_d;
            mask_q        <= mask_d;
            exp_cnt_q     <= exp_cnt_d;
            unc_q         <= unc_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_err_cnt_q <= out_err_cnt_d;
            out_unc_q     <= out_unc_d;
            busy_q        <= busy_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_err_cnt       = out_err_cnt_q;
    assign out_uncorrectable = out_unc_q;
    assign busy              = busy_q;

endmodule

// File: doc/bch_dec2_seq.md
Name: bch_dec2_seq

Overview:
- Parametrised, sequential, double-error-correcting binary BCH decoder over GF(2^M).
- Successor to the fixed GF(16) combinational (15,7) decoder path. Field width and primitive polynomial are parameters; N = 2^M-1.
- Computes syndromes serially (Horner), solves an inversion-free t=2 locator, and runs a serial Chien search.
- Adds valid/ready handshakes, error count and uncorrectable-pattern detection.
- Sits between the pin-level wrapper and downstream consumers of corrected codewords.

Parameters:
- M, 4, field width in bits; legal range 3..8. N = 2^M-1 is a derived localparam.
- PRIM_POLY, 5'b10011, primitive polynomial for GF(2^M), M+1 bits wide, MSB set (default x^4+x+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input codeword valid.
- in_ready  out  1  decoder can accept a codeword.
- in_data  in  N  received codeword; bit i is the coefficient of x^i.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N  corrected codeword; the received word unchanged if uncorrectable.
- out_err_cnt  out  2  number of bits corrected (0, 1 or 2).
- out_uncorrectable  out  1  the pattern is not decodable within t=2.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock domain.
- Reset is synchronous and active-high: rst sampled high at a clk edge forces IDLE. All outputs go to 0 except in_ready, which is 1. All internal registers are cleared. Reset mid-operation discards the word in flight without emitting it.
- FSM states are IDLE, SYND, SOLVE, CHIEN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_data into r_buf, clear S1/S3, set idx=N-1, go to SYND.
- SYND (exactly N cycles, idx from N-1 down to 0):
  - S1 <= S1*alpha ^ r_buf[idx].
  - S3 <= S3*alpha^3 ^ r_buf[idx].
  - All GF multiplies are by constants and reduce by PRIM_POLY.
- SOLVE (1 cycle):
  - D = S3 ^ S1^3.
  - Classification:
    - S1=0, S3=0: expect 0 errors.
    - S1!=0, D=0: expect 1 error.
    - S1!=0, D!=0: expect 2 errors.
    - S1=0, S3!=0: uncorrectable.
  - Load the scaled locator L(x) = S1 + S1^2*x + D*x^2 (no inversion needed): c0=S1, c1=S1^2, c2=D.
  - Set j=0, root count=0, error mask=0.
- CHIEN (exactly N cycles, j = 0..N-1):
  - If c0^c1^c2 == 0 at step j, set mask[j] and increment root count (saturate at 3).
  - Then c1 <= c1*alpha^-1 and c2 <= c2*alpha^-2.
  - For the 0-error and uncorrectable cases, CHIEN still runs so latency stays fixed, but no mask bits are set.
- At CHIEN exit, compute the result:
  - If root count equals the expected count: out_data = r_buf ^ mask, out_err_cnt = count, out_uncorrectable = 0.
  - Otherwise, and for the uncorrectable case: out_data = r_buf, out_err_cnt = 0, out_uncorrectable = 1.
- DONE:
  - out_valid=1.
  - out_data, out_err_cnt and out_uncorrectable stay stable until out_ready.
  - On out_valid&&out_ready, go to IDLE and drop out_valid.
- Latency and throughput:
  - With out_ready held high, out_valid rises 2N+2 cycles after the accepting edge (32 for M=4).
  - in_ready is 0 from the accept edge until DONE completes, so the decoder is not pipelined and handles one word at a time.
  - Back-to-back throughput is 2N+4 cycles per word.
- in_valid while in_ready=0 is ignored; the source must hold the word.

Test Plan:
- M=4. Input 15'h01D1 (generator polynomial, a valid codeword) -> out_data=15'h01D1, err_cnt=0, uncorrectable=0, out_valid 32 cycles after accept.
- M=4. Input 15'h41D1 (bit 14 flipped) -> out_data=15'h01D1, err_cnt=1, uncorrectable=0.
- M=4. Input 15'h0808 (all-zero codeword, bits 3 and 11 flipped) -> out_data=0, err_cnt=2, uncorrectable=0.
- M=4. Input 15'h0013 (bits 0, 1, 4 set; S1=0, S3=6) -> out_data=15'h0013, err_cnt=0, uncorrectable=1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 -> one transfer, in_ready=1 on the next cycle.
- Reset mid-operation: assert rst for 1 cycle during CHIEN -> next cycle all outputs 0 except in_ready=1. The next codeword then decodes normally.
